// File: rtl/pim_pkg.sv
// Shared types for the PIM port arbiter: FSM states, requester ids and the
// latched transaction record.
package pim_pkg;

    localparam int CNT_W    = 4;
    localparam int PIM_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } pim_state_e;

    typedef enum logic {
        SRC_CORE = 1'b0,
        SRC_SPI  = 1'b1
    } pim_src_e;

    // Default-width transaction record; the top re-declares it at its XLEN.
    typedef struct packed {
        logic                we;
        logic [PIM_XLEN-1:0] addr;
        logic [PIM_XLEN-1:0] wdata;
    } pim_req_t;

endpackage

// File: rtl/pim_rr_arb.sv
// Two-way round-robin selector. Bit 0 is the core, bit 1 is SPI; on a tie
// the requester that was not granted last wins.
module pim_rr_arb
    import pim_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    pim_src_e last_q;

    always_comb begin
        grant_o = 2'b00;
        unique case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (last_q == SRC_SPI) ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

    // Reset to SPI so the core wins the first conflict.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= SRC_SPI;
        end else if (advance_i && (grant_o != 2'b00)) begin
            last_q <= grant_o[1] ? SRC_SPI : SRC_CORE;
        end
    end

endmodule

// File: rtl/pim_arbiter.sv
// Shares the PIM memory port between the core and the SPI loader: one
// transaction at a time, one-cycle access strobe, fixed read latency.
module pim_arbiter
    import pim_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            core_req_i,
    input  logic            core_we_i,
    input  logic [XLEN-1:0] core_addr_i,
    input  logic [XLEN-1:0] core_wdata_i,
    output logic            core_gnt_o,
    output logic            core_rvalid_o,
    output logic [XLEN-1:0] core_rdata_o,
    input  logic            spi_req_i,
    input  logic            spi_we_i,
    input  logic [XLEN-1:0] spi_addr_i,
    input  logic [XLEN-1:0] spi_wdata_i,
    output logic            spi_gnt_o,
    output logic            spi_rvalid_o,
    output logic [XLEN-1:0] spi_rdata_o,
    output logic            pim_en_o,
    output logic            pim_we_o,
    output logic [XLEN-1:0] pim_addr_o,
    output logic [XLEN-1:0] pim_wr_o,
    input  logic [XLEN-1:0] pim_rd_i,
    output logic            busy_o
);

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } req_t;

    pim_state_e       state_q, state_d;
    pim_src_e         owner_q, owner_d;
    req_t             req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  core_rdata_q, core_rdata_d;
    logic [XLEN-1:0]  spi_rdata_q, spi_rdata_d;
    logic [1:0]       grant;

    pim_rr_arb u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     ({spi_req_i, core_req_i}),
        .advance_i (state_q == IDLE),
        .grant_o   (grant)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        req_d        = req_q;
        cnt_d        = cnt_q;
        core_rdata_d = core_rdata_q;
        spi_rdata_d  = spi_rdata_q;
        core_gnt_o   = 1'b0;
        spi_gnt_o    = 1'b0;
        pim_en_o     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    core_gnt_o = grant[0];
                    spi_gnt_o  = grant[1];
                    if (grant[1]) begin
                        owner_d = SRC_SPI;
                        req_d   = '{we: spi_we_i, addr: spi_addr_i, wdata: spi_wdata_i};
                    end else begin
                        owner_d = SRC_CORE;
                        req_d   = '{we: core_we_i, addr: core_addr_i, wdata: core_wdata_i};
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                pim_en_o = 1'b1;
                if (req_q.we) begin
                    state_d = RESP;
                end else if (RD_LATENCY == 0) begin
                    if (owner_q == SRC_CORE) core_rdata_d = pim_rd_i;
                    else                     spi_rdata_d  = pim_rd_i;
                    state_d = RESP;
                end else begin
                    cnt_d   = CNT_W'(RD_LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // The count of 1 marks the cycle in which read data is valid.
                if (cnt_q == CNT_W'(1)) begin
                    if (owner_q == SRC_CORE) core_rdata_d = pim_rd_i;
                    else                     spi_rdata_d  = pim_rd_i;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            owner_q      <= SRC_CORE;
            req_q        <= '0;
            cnt_q        <= '0;
            core_rdata_q <= '0;
            spi_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            req_q        <= req_d;
            cnt_q        <= cnt_d;
            core_rdata_q <= core_rdata_d;
            spi_rdata_q  <= spi_rdata_d;
        end
    end

    assign pim_we_o      = (state_q == ACCESS) && req_q.we;
    assign pim_addr_o    = req_q.addr;
    assign pim_wr_o      = req_q.wdata;
    assign busy_o        = (state_q != IDLE);
    assign core_rvalid_o = (state_q == RESP) && (owner_q == SRC_CORE);
    assign spi_rvalid_o  = (state_q == RESP) && (owner_q == SRC_SPI);

    // A write response shows zero without disturbing the last read data held.
    assign core_rdata_o  = (core_rvalid_o && req_q.we) ? '0 : core_rdata_q;
    assign spi_rdata_o   = (spi_rvalid_o && req_q.we) ? '0 : spi_rdata_q;

endmodule
